// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start detection, bit timing, LSB-first deserialization,
// parity/stop checking with a one-cycle data_valid strobe and error pulses.
module uart_rx_frame_ctrl #(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned PRESCALE_WIDTH = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rx_in,
   input  logic [PRESCALE_WIDTH-1:0] prescalar,
   input  logic                      par_en,
   input  logic                      par_typ,
   input  logic                      sampled_bit,
   output logic                      data_samp_en,
   output logic [PRESCALE_WIDTH-1:0] edge_cnt,
   output logic [3:0]                bit_cnt,
   output logic [DATA_WIDTH-1:0]     p_data,
   output logic                      data_valid,
   output logic                      par_err,
   output logic                      stp_err
);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   localparam logic [PRESCALE_WIDTH-1:0] PsOne    = PRESCALE_WIDTH'(1);
   localparam logic [3:0]                LastData = 4'(DATA_WIDTH);

   state_e                    state_q, state_d;
   logic [PRESCALE_WIDTH-1:0] edge_q, edge_d;
   logic [3:0]                bit_q, bit_d;
   logic [DATA_WIDTH-1:0]     data_q, data_d;
   logic                      samp_en_q, samp_en_d;
   logic                      valid_q, valid_d;
   logic                      par_err_q, par_err_d;
   logic                      stp_err_q, stp_err_d;
   logic                      bad_q, bad_d;
   logic                      bit_end;
   logic                      exp_par;

   assign bit_end = (state_q != StIdle) && (edge_q == prescalar - PsOne);
   assign exp_par = par_typ ? ~^data_q : ^data_q;

   always_comb begin
      state_d   = state_q;
      edge_d    = edge_q;
      bit_d     = bit_q;
      data_d    = data_q;
      bad_d     = bad_q;
      valid_d   = 1'b0;
      par_err_d = 1'b0;
      stp_err_d = 1'b0;

      if (state_q != StIdle) begin
         if (bit_end) begin
            edge_d = '0;
            bit_d  = bit_q + 4'd1;
         end else begin
            edge_d = edge_q + PsOne;
         end
      end

      unique case (state_q)
         StIdle: begin
            edge_d = '0;
            bit_d  = '0;
            bad_d  = 1'b0;
            if (!rx_in) state_d = StStart;
         end
         StStart: begin
            if (bit_end) begin
               if (sampled_bit) begin
                  // Start bit did not hold low: treat as line noise
                  state_d = StIdle;
                  edge_d  = '0;
                  bit_d   = '0;
               end else begin
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (bit_end) begin
               data_d = {sampled_bit, data_q[DATA_WIDTH-1:1]};
               if (bit_q == LastData) state_d = par_en ? StParity : StStop;
            end
         end
         StParity: begin
            if (bit_end) begin
               if (sampled_bit != exp_par) begin
                  par_err_d = 1'b1;
                  bad_d     = 1'b1;
               end
               state_d = StStop;
            end
         end
         StStop: begin
            if (bit_end) begin
               state_d = StIdle;
               edge_d  = '0;
               bit_d   = '0;
               bad_d   = 1'b0;
               if (!sampled_bit) stp_err_d = 1'b1;
               else if (!bad_q)  valid_d   = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      samp_en_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         edge_q    <= '0;
         bit_q     <= '0;
         data_q    <= '0;
         samp_en_q <= 1'b0;
         valid_q   <= 1'b0;
         par_err_q <= 1'b0;
         stp_err_q <= 1'b0;
         bad_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         edge_q    <= edge_d;
         bit_q     <= bit_d;
         data_q    <= data_d;
         samp_en_q <= samp_en_d;
         valid_q   <= valid_d;
         par_err_q <= par_err_d;
         stp_err_q <= stp_err_d;
         bad_q     <= bad_d;
      end
   end

   assign data_samp_en = samp_en_q;
   assign edge_cnt     = edge_q;
   assign bit_cnt      = bit_q;
   assign p_data       = data_q;
   assign data_valid   = valid_q;
   assign par_err      = par_err_q;
   assign stp_err      = stp_err_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: serial transmitter, majority-vote sampler model and an
// event scoreboard checking strobe timing, flags and received data.
module tb_uart_rx_frame_ctrl;

   localparam int DW = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_in;
   logic [5:0] prescalar;
   logic       par_en;
   logic       par_typ;
   logic       sampled_bit = 1'b1;
   logic       data_samp_en;
   logic [5:0] edge_cnt;
   logic [3:0] bit_cnt;
   logic [7:0] p_data;
   logic       data_valid;
   logic       par_err;
   logic       stp_err;

   uart_rx_frame_ctrl #(
      .DATA_WIDTH    (DW),
      .PRESCALE_WIDTH(6)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_in       (rx_in),
      .prescalar   (prescalar),
      .par_en      (par_en),
      .par_typ     (par_typ),
      .sampled_bit (sampled_bit),
      .data_samp_en(data_samp_en),
      .edge_cnt    (edge_cnt),
      .bit_cnt     (bit_cnt),
      .p_data      (p_data),
      .data_valid  (data_valid),
      .par_err     (par_err),
      .stp_err     (stp_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Sampler: three votes around mid-bit, result registered at edge prescalar/2+2
   logic [2:0] votes = 3'b111;
   always @(posedge clk) begin
      if (data_samp_en) begin
         if (int'(edge_cnt) == int'(prescalar) / 2 - 1) votes[0] <= rx_in;
         if (int'(edge_cnt) == int'(prescalar) / 2)     votes[1] <= rx_in;
         if (int'(edge_cnt) == int'(prescalar) / 2 + 1) votes[2] <= rx_in;
         if (int'(edge_cnt) == int'(prescalar) / 2 + 2)
            sampled_bit <= (votes[0] & votes[1]) | (votes[0] & votes[2]) | (votes[1] & votes[2]);
      end
   end

   typedef struct {
      int         cyc;
      bit         valid;
      bit         perr;
      bit         serr;
      logic [7:0] data;
   } ev_t;

   ev_t exp_q[$];
   ev_t mon_ev;
   int  n_vec     = 0;
   int  n_err     = 0;
   int  next_free = 0;

   task automatic chk(input string name, input int act, input int req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_ev(input int c, input bit v, input bit pe, input bit se,
                          input logic [7:0] d);
      ev_t e;
      e.cyc = c; e.valid = v; e.perr = pe; e.serr = se; e.data = d;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (data_valid || par_err || stp_err) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_strobe", {29'd0, data_valid, par_err, stp_err}, 0);
         end else begin
            mon_ev = exp_q.pop_front();
            chk("strobe_cycle", cyc, mon_ev.cyc);
            chk("strobe_flags", {29'd0, data_valid, par_err, stp_err},
                {29'd0, mon_ev.valid, mon_ev.perr, mon_ev.serr});
            if (mon_ev.valid) chk("p_data", p_data, mon_ev.data);
         end
      end
   end

   task automatic check_all_zero(input string tag);
      chk({tag, "_edge_cnt"}, edge_cnt, 0);
      chk({tag, "_bit_cnt"}, bit_cnt, 0);
      chk({tag, "_p_data"}, p_data, 0);
      chk({tag, "_strobes"}, {28'd0, data_samp_en, data_valid, par_err, stp_err}, 0);
   endtask

   // Drives one frame starting this cycle; abort_bit >= 0 resets the DUT inside that bit.
   task automatic send_frame(input logic [7:0] d, input bit flip, input bit stop,
                             input int abort_bit);
      logic bits [0:11];
      int   ps, nb, entry, ones;
      ps   = int'(prescalar);
      ones = $countones(d);
      bits[0] = 1'b0;
      for (int i = 0; i < DW; i++) bits[1 + i] = d[i];
      nb = DW + 1;
      if (par_en) begin
         bits[nb] = ((par_typ ? (ones % 2 == 0) : (ones % 2 == 1)) ? 1'b1 : 1'b0) ^ flip;
         nb++;
      end
      bits[nb] = stop;
      nb++;
      // DUT enters START the cycle after it first sees the line low while idle
      entry = (cyc + 1 > next_free) ? cyc + 1 : next_free;
      if (abort_bit < 0) begin
         if (par_en && flip) push_ev(entry + (DW + 2) * ps, 1'b0, 1'b1, 1'b0, 8'h00);
         if (!stop)          push_ev(entry + nb * ps, 1'b0, 1'b0, 1'b1, 8'h00);
         else if (!(par_en && flip)) push_ev(entry + nb * ps, 1'b1, 1'b0, 1'b0, d);
         next_free = entry + nb * ps + 1;
      end
      for (int b = 0; b < nb; b++) begin
         rx_in = bits[b];
         if (b == abort_bit) begin
            tick();
            tick();
            chk("abort_bit_cnt", bit_cnt, abort_bit);
            #1 rst = 1'b0;
            #1 check_all_zero("async_reset");
            tick();
            tick();
            rx_in = 1'b1;
            #2 rst = 1'b1;
            tick();
            next_free = 0;
            return;
         end
         repeat (ps) tick();
      end
   endtask

   task automatic idle_gap(input int n);
      rx_in = 1'b1;
      repeat (n) tick();
   endtask

   initial begin
      int   glitch_s;
      bit   prev_b2b;
      int   sel;
      rst       = 1'b0;
      rx_in     = 1'b1;
      prescalar = 6'd8;
      par_en    = 1'b0;
      par_typ   = 1'b0;
      repeat (3) tick();
      check_all_zero("reset");
      #2 rst = 1'b1;
      repeat (5) tick();

      send_frame(8'hA5, 1'b0, 1'b1, -1);
      idle_gap(10);

      prescalar = 6'd16; par_en = 1'b1; par_typ = 1'b0;
      send_frame(8'h3C, 1'b0, 1'b1, -1);
      idle_gap(10);
      send_frame(8'h3C, 1'b1, 1'b1, -1);
      idle_gap(10);

      prescalar = 6'd32; par_en = 1'b1; par_typ = 1'b1;
      send_frame(8'h01, 1'b0, 1'b0, -1);
      idle_gap(10);

      prescalar = 6'd8; par_en = 1'b0; par_typ = 1'b0;
      glitch_s = cyc;
      rx_in = 1'b0;
      repeat (3) tick();
      rx_in = 1'b1;
      while (cyc < glitch_s + 10) tick();
      chk("glitch_edge_cnt", edge_cnt, 0);
      chk("glitch_bit_cnt", bit_cnt, 0);
      chk("glitch_samp_en", data_samp_en, 0);
      idle_gap(10);

      send_frame(8'h55, 1'b0, 1'b1, -1);
      send_frame(8'hF0, 1'b0, 1'b1, -1);
      idle_gap(10);

      send_frame(8'h7E, 1'b0, 1'b1, 4);
      idle_gap(10);
      send_frame(8'h81, 1'b0, 1'b1, -1);

      prev_b2b = 1'b1;
      for (int i = 0; i < 24; i++) begin
         // Back-to-back frames keep the previous config and are never chained
         if (!prev_b2b && $urandom_range(0, 3) == 0) begin
            prev_b2b = 1'b1;
         end else begin
            idle_gap($urandom_range(4, 20));
            sel       = $urandom_range(0, 2);
            prescalar = (sel == 0) ? 6'd8 : (sel == 1) ? 6'd16 : 6'd32;
            par_en    = 1'($urandom_range(0, 1));
            par_typ   = 1'($urandom_range(0, 1));
            prev_b2b  = 1'b0;
         end
         send_frame(8'($urandom), par_en && ($urandom_range(0, 4) == 0),
                    $urandom_range(0, 5) != 0, -1);
      end
      idle_gap(4);

      for (int t = 0; t < 1000 && exp_q.size() != 0; t++) tick();
      chk("pending_events", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
      $fatal(1);
   end

endmodule
